// File: rtl/lsu_mem_port.sv
// MEM-stage load/store initiator: validates a request, drives byte-lane strobes to the data
// memory, waits for ready with an optional timeout, and reports the result with a done pulse.
module lsu_mem_port #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid_i,
    input  logic        req_load_i,
    input  logic        req_store_i,
    input  logic [1:0]  req_size_i,
    input  logic        req_unsigned_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        req_ready_o,
    output logic        done_o,
    output logic [1:0]  err_o,
    output logic [31:0] rdata_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_be_o,
    output logic        mem_sign_o,
    output logic        mem_read_o,
    output logic        mem_write_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_ready_i
);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StAccess = 2'd1;
    localparam logic [1:0] StResp   = 2'd2;

    localparam logic [1:0] ErrOk       = 2'b00;
    localparam logic [1:0] ErrMisalign = 2'b01;
    localparam logic [1:0] ErrTimeout  = 2'b10;
    localparam logic [1:0] ErrIllegal  = 2'b11;

    // Keep a 1-bit counter when the timeout is disabled so the width never collapses to zero.
    localparam int unsigned CntW     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int unsigned CntLastI = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [CntW-1:0] CntLast = CntW'(CntLastI);

    logic [1:0]      state_q;
    logic [CntW-1:0] cnt_q;
    logic            done_q;
    logic [1:0]      err_q;
    logic [31:0]     rdata_q;
    logic [31:0]     addr_q;
    logic [31:0]     wdata_q;
    logic [3:0]      be_q;
    logic            sign_q;
    logic            read_q;
    logic            write_q;

    logic       illegal;
    logic       misaligned;
    logic       timeout_hit;
    logic [3:0] be;

    always_comb begin
        illegal    = (req_load_i == req_store_i) || (req_size_i == 2'b11);
        misaligned = ((req_size_i == 2'b01) && req_addr_i[0]) ||
                     ((req_size_i == 2'b10) && (req_addr_i[1:0] != 2'b00));
        be = 4'b0000;
        case (req_size_i)
            2'b00:   be = 4'b0001 << req_addr_i[1:0];
            2'b01:   be = req_addr_i[1] ? 4'b1100 : 4'b0011;
            2'b10:   be = 4'b1111;
            default: be = 4'b0000;
        endcase
        timeout_hit = (TIMEOUT != 0) && (cnt_q == CntLast);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= ErrOk;
            rdata_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            sign_q  <= 1'b0;
            read_q  <= 1'b0;
            write_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (req_valid_i) begin
                        if (illegal || misaligned) begin
                            // Illegal wins over misaligned; no memory cycle is issued.
                            state_q <= StResp;
                            done_q  <= 1'b1;
                            err_q   <= illegal ? ErrIllegal : ErrMisalign;
                            rdata_q <= '0;
                        end else begin
                            state_q <= StAccess;
                            cnt_q   <= '0;
                            addr_q  <= req_addr_i;
                            wdata_q <= req_wdata_i;
                            be_q    <= be;
                            sign_q  <= req_load_i & ~req_unsigned_i;
                            read_q  <= req_load_i;
                            write_q <= req_store_i;
                        end
                    end
                end
                StAccess: begin
                    // Ready takes precedence over a timeout expiring in the same cycle.
                    if (mem_ready_i) begin
                        state_q <= StResp;
                        done_q  <= 1'b1;
                        err_q   <= ErrOk;
                        rdata_q <= read_q ? mem_rdata_i : 32'd0;
                        read_q  <= 1'b0;
                        write_q <= 1'b0;
                    end else if (timeout_hit) begin
                        state_q <= StResp;
                        done_q  <= 1'b1;
                        err_q   <= ErrTimeout;
                        rdata_q <= '0;
                        read_q  <= 1'b0;
                        write_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StResp: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign req_ready_o = (state_q == StIdle);
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign rdata_o     = rdata_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign mem_be_o    = be_q;
    assign mem_sign_o  = sign_q;
    assign mem_read_o  = read_q;
    assign mem_write_o = write_q;

endmodule
